div_clk_checker: RTL and testbench
==================================

DIV_CLK_CHECKER -- requirements
Module: div_clk_checker

Interface
REQ-001 Parameter W, default 8: width of the period and high-time counters and measurement outputs.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive matching periods required to assert locked.
REQ-003 clk_in  input  1  Sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-low; asserted when 0, clears all state immediately, released synchronously to clk_in.
REQ-005 div_in  input  1  Divided clock under test, treated as asynchronous data.
REQ-006 enable  input  1  0 forces IDLE; 1 runs the checker.
REQ-007 exp_period  input  W  Expected div_in period in clk_in cycles; held static while enable=1.
REQ-008 period  output  W  Last measured period in clk_in cycles.
REQ-009 high_time  output  W  Cycles div_in was sampled high within the last measured period.
REQ-010 valid  output  1  One-cycle pulse when period and high_time update.
REQ-011 locked  output  1  High while in LOCK.
REQ-012 err  output  1  High while in ERR.

Function
REQ-013 The block SHALL pass div_in through a 2-flop synchronizer to div_s, then register div_s to div_d.
REQ-014 A rising edge SHALL be detected in the cycle where div_s=1 and div_d=0; detection lags div_in by 2-3 clk_in cycles.
REQ-015 Counter cnt SHALL load 1 on each detected edge and otherwise increment, saturating at 2^W-1.
REQ-016 Counter hcnt SHALL load div_s on each detected edge and otherwise add div_s, saturating at 2^W-1.
REQ-017 On each detected edge in MEAS or LOCK: period <= cnt and high_time <= hcnt (values before reload), with valid=1 in the following cycle.
REQ-018 No valid SHALL be produced on the first edge after entering ACQ.
REQ-019 A match SHALL be period == exp_period. If exp_period < 2, no match occurs, so locked never asserts.
REQ-020 The FSM SHALL have states IDLE, ACQ, MEAS, LOCK and ERR.
REQ-021 Any state -> IDLE when enable=0, taking priority over all other transitions. In IDLE, cnt, hcnt, match_cnt, period, high_time, valid, locked and err are all 0.
REQ-022 IDLE -> ACQ when enable=1.
REQ-023 ACQ -> MEAS on the first detected edge; cnt and hcnt are reloaded on that edge.
REQ-024 MEAS behaviour:
  - each match increments match_cnt;
  - a mismatch clears match_cnt and the FSM stays in MEAS;
  - when match_cnt would reach LOCK_CNT, go to LOCK.
REQ-025 MEAS -> ACQ, with match_cnt cleared, when cnt reaches 2*exp_period with no edge (timeout; comparison at W+1 bits).
REQ-026 LOCK -> ERR on any mismatch, or on timeout as defined in REQ-025.
REQ-027 ERR SHALL be sticky until enable=0 or reset. Measurements (period, high_time, valid) continue to update while in ERR.
REQ-028 Simultaneous timeout and edge in the same cycle SHALL be treated as an edge; no timeout is taken.
REQ-029 A saturated cnt SHALL be reported as period=2^W-1, which is a mismatch unless exp_period=2^W-1.

Reset
REQ-030 While reset=0, state=IDLE and every output and counter is 0, independent of clk_in.
REQ-031 After reset release with enable=1, the FSM SHALL enter ACQ on the first clk_in edge.
REQ-032 Reset asserted mid-measurement SHALL discard the partial count; there is no valid pulse for the interrupted period.

Verification
REQ-033 Divide-by-3 stimulus (high 1.5 clk_in cycles), exp_period=3, LOCK_CNT=4 -> period=3, high_time in {1,2}, locked=1 after the 4th matching valid, err=0 throughout.
REQ-034 Same stimulus, exp_period=4 -> valid pulses every 3 cycles with period=3, locked stays 0, err stays 0, FSM stays in MEAS.
REQ-035 Locked on divide-by-3, then div_in held constant -> err=1 and locked=0 when cnt reaches 6; err stays high until enable is pulsed to 0.
REQ-036 Locked, then one period stretched to 4 -> period=4 with valid, err=1 the next cycle, locked=0.
REQ-037 reset driven low mid-MEAS with clk_in stopped -> all outputs 0 immediately; after release, no valid until two edges have been seen.
REQ-038 W=4, div_in stuck low with exp_period=15 in MEAS -> timeout returns FSM to ACQ at cnt=30 (W+1-bit compare); no valid pulse occurs.

Source files
------------

// File: rtl/div_clk_checker.sv
// div_clk_checker
// Measures the period and high time of a divided clock (div_in) in clk_in
// cycles, compares each period against exp_period and reports lock/error.
//
// Ports:
//   clk_in      sole clock, rising edge
//   reset       asynchronous active-low reset
//   div_in      divided clock under test (asynchronous, synchronised here)
//   enable      0 holds the checker in IDLE, 1 runs it
//   exp_period  expected div_in period in clk_in cycles (static while enabled)
//   period      last measured period
//   high_time   cycles div_in was sampled high within that period
//   valid       one-cycle pulse when period/high_time update
//   locked      high while in LOCK
//   err         high while in ERR (sticky until enable drops)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | disabled, all counters and outputs cleared
// ACQ   | waiting for the first div_in edge to start a measurement
// MEAS  | measuring, counting consecutive matching periods
// LOCK  | LOCK_CNT consecutive matches seen
// ERR   | mismatch or timeout after lock; measurements keep updating

module div_clk_checker #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         div_in,
  input  logic         enable,
  input  logic [W-1:0] exp_period,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         err
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LAST_MATCH = MW'(LOCK_CNT - 1);
  localparam logic [W-1:0]  SAT        = '1;
  localparam logic [W:0]    CNT_MAX    = '1;

  typedef enum logic [2:0] {IDLE, ACQ, MEAS, LOCK, ERR} state_t;

  state_t        state;
  logic          sync1, div_s, div_d;
  // One bit wider than the reported period so that a timeout at
  // 2*exp_period is reachable even when exp_period is near 2^W-1.
  logic [W:0]    cnt;
  logic [W-1:0]  hcnt;
  logic [MW-1:0] match_cnt;

  logic         rise;
  logic [W-1:0] cnt_sat;
  logic         match;
  logic         timeout;

  always_comb begin
    rise    = div_s & ~div_d;
    cnt_sat = (cnt > {1'b0, SAT}) ? SAT : cnt[W-1:0];
    // Periods below 2 cannot be measured meaningfully, so never match them.
    match   = (exp_period > W'(1)) && (cnt_sat == exp_period);
    // An edge in the same cycle wins over the timeout.
    timeout = ~rise && (cnt == {exp_period, 1'b0});
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      div_s <= 1'b0;
      div_d <= 1'b0;
    end else begin
      sync1 <= div_in;
      div_s <= sync1;
      div_d <= div_s;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      match_cnt <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      match_cnt <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (state != IDLE) begin
        if (rise) begin
          cnt  <= {{W{1'b0}}, 1'b1};
          hcnt <= {{(W-1){1'b0}}, div_s};
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (div_s && (hcnt != SAT)) hcnt <= hcnt + 1'b1;
        end
      end

      // Values captured are those before the reload above.
      if (rise && (state inside {MEAS, LOCK, ERR})) begin
        period    <= cnt_sat;
        high_time <= hcnt;
        valid     <= 1'b1;
      end

      case (state)
        IDLE: state <= ACQ;
        ACQ: begin
          if (rise) state <= MEAS;
        end
        MEAS: begin
          if (rise) begin
            if (match) begin
              if (match_cnt == LAST_MATCH) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end else if (timeout) begin
            state     <= ACQ;
            match_cnt <= '0;
          end
        end
        LOCK: begin
          if ((rise && !match) || timeout) begin
            state  <= ERR;
            locked <= 1'b0;
            err    <= 1'b1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// tb_div_clk_checker
// Directed bench for div_clk_checker: an 8-bit instance driven by a
// behavioural divided-clock generator and a 4-bit instance driven by
// hand-placed pulses for the wide timeout compare.

module tb_div_clk_checker;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       div_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] exp_period = '0;
  logic [7:0] period, high_time;
  logic       valid, locked, err;

  logic       div4 = 1'b0;
  logic       enable4 = 1'b0;
  logic [3:0] exp4 = '0;
  logic [3:0] period4, high4;
  logic       valid4, locked4, err4;

  int n_tests = 0;
  int n_fail  = 0;

  bit clk_run     = 1'b1;
  int gen_period  = 0;
  bit gen_level   = 1'b0;
  int stretch_req = 0;
  int stretch_ack = 0;

  int         err_cycles  = 0;
  int         lock_cycles = 0;
  int         v4_cnt      = 0;
  logic [3:0] v4_last     = '0;

  div_clk_checker #(.W(8), .LOCK_CNT(4)) dut (
    .clk_in(clk_in), .reset(reset), .div_in(div_in), .enable(enable),
    .exp_period(exp_period), .period(period), .high_time(high_time),
    .valid(valid), .locked(locked), .err(err)
  );

  div_clk_checker #(.W(4), .LOCK_CNT(4)) dut4 (
    .clk_in(clk_in), .reset(reset), .div_in(div4), .enable(enable4),
    .exp_period(exp4), .period(period4), .high_time(high4),
    .valid(valid4), .locked(locked4), .err(err4)
  );

  // Toggle slots every 5 ns are kept even while stopped so the phase
  // relationship with the divided clock survives a clock stop.
  initial begin
    forever begin
      #5;
      if (clk_run) clk_in = ~clk_in;
    end
  end

  // Divided clock: edges land on 2 mod 5 ns, never on a clk_in edge.
  initial begin
    int p;
    #2;
    forever begin
      if (stretch_req != stretch_ack) begin
        p = 4;
        stretch_ack = stretch_req;
      end else begin
        p = gen_period;
      end
      if (p == 0) begin
        div_in = gen_level;
        #10;
      end else begin
        div_in = 1'b1;
        #(p * 5);
        div_in = 1'b0;
        #(p * 5);
      end
    end
  end

  always @(negedge clk_in) begin
    if (err) err_cycles++;
    if (locked) lock_cycles++;
    if (valid4) begin
      v4_cnt++;
      v4_last = period4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_in);
      if (valid) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic pulse4(input int spacing);
    div4 = 1'b1;
    repeat (2) @(negedge clk_in);
    div4 = 1'b0;
    repeat (spacing - 2) @(negedge clk_in);
  endtask

  initial begin
    bit ok;
    int cyc;
    int n;
    int e0;
    int l0;
    int base;

    // reset state
    #23;
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);

    // divide-by-3, exp 3: lock after the 4th matching valid
    @(negedge clk_in);
    reset = 1'b1;
    enable = 1'b1;
    exp_period = 8'd3;
    gen_period = 3;
    e0 = err_cycles;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(20, ok, cyc);
      chk($sformatf("lock_valid%0d_seen", k), ok, 1);
      chk($sformatf("lock_valid%0d_period", k), period, 3);
      chk($sformatf("lock_valid%0d_ht_1or2", k), (high_time == 8'd1) || (high_time == 8'd2), 1);
      chk($sformatf("lock_valid%0d_locked", k), locked, (k == 4) ? 1 : 0);
    end
    chk("lock_err_never", err_cycles - e0, 0);

    // one period stretched to 4 while locked
    stretch_req++;
    n = 0;
    do begin
      wait_valid(20, ok, cyc);
      n++;
    end while (ok && period == 8'd3 && n < 6);
    chk("stretch_valid_seen", ok, 1);
    chk("stretch_period", period, 4);
    @(negedge clk_in);
    chk("stretch_err", err, 1);
    chk("stretch_locked_drop", locked, 0);
    wait_valid(20, ok, cyc);
    chk("stretch_meas_continue", ok, 1);
    chk("stretch_meas_period", period, 3);
    repeat (10) @(negedge clk_in);
    chk("stretch_err_sticky", err, 1);
    enable = 1'b0;
    @(negedge clk_in);
    chk("disable_err", err, 0);
    chk("disable_locked", locked, 0);
    chk("disable_period", period, 0);

    // lock, then freeze div_in low: timeout at cnt=6 -> ERR
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (locked) break;
    end
    chk("hold_locked_first", locked, 1);
    wait_valid(20, ok, cyc);
    gen_level = 1'b0;
    gen_period = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (valid) n = 0;
      else n++;
      if (err) break;
    end
    chk("hold_err", err, 1);
    chk("hold_locked_drop", locked, 0);
    chk("hold_timeout_delay", n, 6);
    repeat (10) @(negedge clk_in);
    chk("hold_err_sticky", err, 1);
    enable = 1'b0;
    @(negedge clk_in);
    chk("hold_err_clear", err, 0);

    // divide-by-3 with exp 4: valid every 3 cycles, never locks
    exp_period = 8'd4;
    gen_period = 3;
    enable = 1'b1;
    e0 = err_cycles;
    l0 = lock_cycles;
    wait_valid(20, ok, cyc);
    chk("miss_first_valid", ok, 1);
    for (int k = 2; k <= 6; k++) begin
      wait_valid(10, ok, cyc);
      chk($sformatf("miss_valid%0d_seen", k), ok, 1);
      chk($sformatf("miss_valid%0d_spacing", k), cyc, 3);
      chk($sformatf("miss_valid%0d_period", k), period, 3);
    end
    chk("miss_never_locked", lock_cycles - l0, 0);
    chk("miss_never_err", err_cycles - e0, 0);

    // reset mid-MEAS with the clock stopped
    chk("rst_mid_pre_period", period, 3);
    @(negedge clk_in);
    #1;
    clk_run = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk("rst_mid_period", period, 0);
    chk("rst_mid_high_time", high_time, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_err", err, 0);
    #18;
    clk_run = 1'b1;
    @(negedge div_in);
    @(negedge clk_in);
    reset = 1'b1;
    wait_valid(20, ok, cyc);
    chk("rst_mid_valid_after", ok, 1);
    chk("rst_mid_two_edges", cyc >= 6, 1);
    chk("rst_mid_first_period", period, 3);

    // W=4, exp 15: saturated period, then timeout at cnt=30
    enable4 = 1'b1;
    exp4 = 4'd15;
    repeat (2) @(negedge clk_in);
    pulse4(20);
    base = v4_cnt;
    chk("w4_no_valid_first_edge", v4_cnt - base, 0);
    pulse4(40);
    chk("w4_sat_valid", v4_cnt - base, 1);
    chk("w4_sat_period", v4_last, 15);
    pulse4(6);
    chk("w4_timeout_no_valid", v4_cnt - base, 1);
    pulse4(6);
    chk("w4_remeasure_valid", v4_cnt - base, 2);
    chk("w4_remeasure_period", v4_last, 6);
    chk("w4_err", err4, 0);
    chk("w4_locked", locked4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
